// File: rtl/uart_rx_pkg.sv
// Shared UART types: rx/tx state enums and the parity helper.
// UART_RX_PARITY_EN adds the RX_PARITY state to the rx enum.
package uart_rx_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } uart_tx_state_e;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } uart_rx_state_e;
`else
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } uart_rx_state_e;
`endif

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side byte handshake and error pulses of the UART receiver.
interface uart_rx_if;
    logic [7:0] uart_rx_data_o;
    logic       uart_rx_data_vld_o;
    logic       uart_rx_data_rdy_i;
    logic       uart_rx_frame_err_o;
    logic       uart_rx_overrun_o;
    logic       uart_rx_parity_err_o;

    modport master (
        output uart_rx_data_o,
        output uart_rx_data_vld_o,
        input  uart_rx_data_rdy_i,
        output uart_rx_frame_err_o,
        output uart_rx_overrun_o,
        output uart_rx_parity_err_o
    );

    modport slave (
        input  uart_rx_data_o,
        input  uart_rx_data_vld_o,
        output uart_rx_data_rdy_i,
        input  uart_rx_frame_err_o,
        input  uart_rx_overrun_o,
        input  uart_rx_parity_err_o
    );
endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 by default; bit period = uart_rx_baud_div_i + 2 cycles.
// Define UART_RX_PARITY_EN for 8E1 framing with parity error reporting.
module uart_rx
    import uart_rx_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        uart_rx_i,
    input  logic [31:0] uart_rx_baud_div_i,
    uart_rx_if.master   rx_if
);
    logic           rx_s;
    logic           rx_prev_q;
    logic [1:0]     flush_q;
    uart_rx_state_e state_q, state_d;
    logic [31:0]    baud_cnt_q, baud_cnt_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic [7:0]     data_q, data_d;
    logic           vld_q, vld_d;
    logic           frame_err_q, frame_err_d;
    logic           overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
    logic           par_pend_q, par_pend_d;
    logic           parity_err_q, parity_err_d;
`endif
    logic [32:0]    period_m1;
    logic [32:0]    half_m1;
    logic           sample;
    logic           rdy;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (uart_rx_i),
        .q_o     (rx_s)
    );

    assign rdy       = rx_if.uart_rx_data_rdy_i;
    assign period_m1 = {1'b0, uart_rx_baud_div_i} + 33'd1;
    assign half_m1   = (({1'b0, uart_rx_baud_div_i} + 33'd2) >> 1) - 33'd1;
    assign sample    = ({1'b0, baud_cnt_q} == ((state_q == RX_START) ? half_m1 : period_m1));

    always_comb begin
        state_d     = state_q;
        baud_cnt_d  = baud_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        vld_d       = vld_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_pend_d   = par_pend_q;
        parity_err_d = 1'b0;
`endif
        if (vld_q && rdy) begin
            vld_d = 1'b0;
        end

        unique case (state_q)
            RX_IDLE: begin
                baud_cnt_d = '0;
                // Edges are ignored until the synchronizer has flushed its reset value.
                if (flush_q == 2'd3 && rx_prev_q && !rx_s) begin
                    state_d   = RX_START;
                    bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                    par_pend_d = 1'b0;
`endif
                end
            end
            RX_START: begin
                if (sample) begin
                    baud_cnt_d = '0;
                    state_d    = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + 32'd1;
                end
            end
            RX_DATA: begin
                if (sample) begin
                    baud_cnt_d = '0;
                    shift_d    = {rx_s, shift_q[7:1]};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = RX_PARITY;
`else
                        state_d = RX_STOP;
`endif
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 32'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY: begin
                if (sample) begin
                    baud_cnt_d = '0;
                    state_d    = RX_STOP;
                    if (rx_s != even_parity(shift_q)) begin
                        par_pend_d = 1'b1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 32'd1;
                end
            end
`endif
            RX_STOP: begin
                if (sample) begin
                    baud_cnt_d = '0;
                    state_d    = RX_IDLE;
                    if (!rx_s) begin
                        frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (par_pend_q) begin
                        parity_err_d = 1'b1;
`endif
                    end else if (!vld_q || rdy) begin
                        data_d = shift_q;
                        vld_d  = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 32'd1;
                end
            end
            default: begin
                state_d    = RX_IDLE;
                baud_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= RX_IDLE;
            rx_prev_q   <= 1'b1;
            flush_q     <= '0;
            baud_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            vld_q       <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_pend_q   <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rx_prev_q   <= rx_s;
            if (flush_q != 2'd3) begin
                flush_q <= flush_q + 2'd1;
            end
            baud_cnt_q  <= baud_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            vld_q       <= vld_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_pend_q   <= par_pend_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_if.uart_rx_data_o      = data_q;
    assign rx_if.uart_rx_data_vld_o  = vld_q;
    assign rx_if.uart_rx_frame_err_o = frame_err_q;
    assign rx_if.uart_rx_overrun_o   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign rx_if.uart_rx_parity_err_o = parity_err_q;
`else
    assign rx_if.uart_rx_parity_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at div=8 (10-cycle bit period).
module tb_uart_rx;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int PER = 10;
    // falling edge -> vld: 2 sync + 5 half-bit + 9 (or 10) bit periods
    localparam int LAT = 2 + 5 + PER * (9 + int'(PAR_EN));

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        rx_line = 1'b1;
    logic [31:0] div = 32'd8;
    logic        par_flip = 1'b0;

    uart_rx_if bus();

    uart_rx u_dut (
        .clk_i              (clk),
        .rst_n_i            (rst_n),
        .uart_rx_i          (rx_line),
        .uart_rx_baud_div_i (div),
        .rx_if              (bus)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int frame_start = 0;
    int vld_rises = 0;
    int last_rise_cyc = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int pe_cnt = 0;
    logic vld_prev = 1'b0;
    logic [7:0] rx_bytes[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.uart_rx_data_vld_o === 1'b1 && vld_prev !== 1'b1) begin
            vld_rises++;
            last_rise_cyc = cyc;
            rx_bytes.push_back(bus.uart_rx_data_o);
        end
        vld_prev = bus.uart_rx_data_vld_o;
        if (bus.uart_rx_frame_err_o === 1'b1) fe_cnt++;
        if (bus.uart_rx_overrun_o === 1'b1) ov_cnt++;
        if (bus.uart_rx_parity_err_o === 1'b1) pe_cnt++;
    end

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int rst_bit);
        @(negedge clk);
        rx_line = 1'b0;
        frame_start = cyc + 1;
        repeat (PER) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_line = b[i];
            if (i == rst_bit) begin
                repeat (4) @(negedge clk);
                rst_n = 1'b0;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                repeat (PER - 6) @(negedge clk);
            end else begin
                repeat (PER) @(negedge clk);
            end
        end
        if (PAR_EN && rst_bit < 0) begin
            rx_line = (^b) ^ par_flip;
            repeat (PER) @(negedge clk);
        end
        rx_line = stop_bit;
        repeat (PER) @(negedge clk);
        rx_line = 1'b1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (bus.uart_rx_data_o !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %h exp 00", bus.uart_rx_data_o); end
        tests_run++;
        if (bus.uart_rx_data_vld_o !== 1'b0) begin tests_failed++; $display("FAIL reset_vld: got %b exp 0", bus.uart_rx_data_vld_o); end
        tests_run++;
        if (bus.uart_rx_frame_err_o !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_err: got %b exp 0", bus.uart_rx_frame_err_o); end
        tests_run++;
        if (bus.uart_rx_overrun_o !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun: got %b exp 0", bus.uart_rx_overrun_o); end
        tests_run++;
        if (bus.uart_rx_parity_err_o !== 1'b0) begin tests_failed++; $display("FAIL reset_parity_err: got %b exp 0", bus.uart_rx_parity_err_o); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_basic();
        int r0 = vld_rises;
        bus.uart_rx_data_rdy_i = 1'b0;
        send_frame(8'h55, 1'b1, -1);
        repeat (3) @(negedge clk);
        tests_run++;
        if (vld_rises !== r0 + 1) begin tests_failed++; $display("FAIL basic_vld_count: got %0d exp %0d", vld_rises, r0 + 1); end
        tests_run++;
        if (bus.uart_rx_data_o !== 8'h55) begin tests_failed++; $display("FAIL basic_data: got %h exp 55", bus.uart_rx_data_o); end
        tests_run++;
        if (bus.uart_rx_data_vld_o !== 1'b1) begin tests_failed++; $display("FAIL basic_vld_held: got %b exp 1", bus.uart_rx_data_vld_o); end
        tests_run++;
        if (last_rise_cyc - frame_start !== LAT) begin tests_failed++; $display("FAIL basic_latency: got %0d exp %0d", last_rise_cyc - frame_start, LAT); end
        tests_run++;
        if (fe_cnt + ov_cnt + pe_cnt !== 0) begin tests_failed++; $display("FAIL basic_errors: got %0d exp 0", fe_cnt + ov_cnt + pe_cnt); end
        bus.uart_rx_data_rdy_i = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (bus.uart_rx_data_vld_o !== 1'b0) begin tests_failed++; $display("FAIL basic_consume: got %b exp 0", bus.uart_rx_data_vld_o); end
    endtask

    task automatic test_back_to_back();
        int r0 = vld_rises;
        int o0 = ov_cnt;
        bus.uart_rx_data_rdy_i = 1'b1;
        send_frame(8'hA3, 1'b1, -1);
        send_frame(8'h0F, 1'b1, -1);
        repeat (3) @(negedge clk);
        tests_run++;
        if (vld_rises !== r0 + 2) begin tests_failed++; $display("FAIL b2b_vld_count: got %0d exp %0d", vld_rises, r0 + 2); end
        else begin
            tests_run++;
            if (rx_bytes[r0] !== 8'hA3) begin tests_failed++; $display("FAIL b2b_first: got %h exp a3", rx_bytes[r0]); end
            tests_run++;
            if (rx_bytes[r0 + 1] !== 8'h0F) begin tests_failed++; $display("FAIL b2b_second: got %h exp 0f", rx_bytes[r0 + 1]); end
        end
        tests_run++;
        if (ov_cnt !== o0) begin tests_failed++; $display("FAIL b2b_overrun: got %0d exp %0d", ov_cnt, o0); end
    endtask

    task automatic test_overrun();
        int r0 = vld_rises;
        int o0 = ov_cnt;
        bus.uart_rx_data_rdy_i = 1'b0;
        send_frame(8'h11, 1'b1, -1);
        send_frame(8'h22, 1'b1, -1);
        repeat (3) @(negedge clk);
        tests_run++;
        if (ov_cnt !== o0 + 1) begin tests_failed++; $display("FAIL ovr_pulse: got %0d exp %0d", ov_cnt, o0 + 1); end
        tests_run++;
        if (bus.uart_rx_data_o !== 8'h11) begin tests_failed++; $display("FAIL ovr_data_held: got %h exp 11", bus.uart_rx_data_o); end
        tests_run++;
        if (vld_rises !== r0 + 1) begin tests_failed++; $display("FAIL ovr_vld_count: got %0d exp %0d", vld_rises, r0 + 1); end
        tests_run++;
        if (bus.uart_rx_data_vld_o !== 1'b1) begin tests_failed++; $display("FAIL ovr_vld_held: got %b exp 1", bus.uart_rx_data_vld_o); end
        bus.uart_rx_data_rdy_i = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (bus.uart_rx_data_vld_o !== 1'b0) begin tests_failed++; $display("FAIL ovr_consume: got %b exp 0", bus.uart_rx_data_vld_o); end
    endtask

    task automatic test_frame_err();
        int r0 = vld_rises;
        int f0 = fe_cnt;
        bus.uart_rx_data_rdy_i = 1'b1;
        send_frame(8'hFF, 1'b0, -1);
        repeat (PER) @(negedge clk);
        tests_run++;
        if (fe_cnt !== f0 + 1) begin tests_failed++; $display("FAIL ferr_pulse: got %0d exp %0d", fe_cnt, f0 + 1); end
        tests_run++;
        if (vld_rises !== r0) begin tests_failed++; $display("FAIL ferr_no_vld: got %0d exp %0d", vld_rises, r0); end
        send_frame(8'h5A, 1'b1, -1);
        repeat (3) @(negedge clk);
        tests_run++;
        if (vld_rises !== r0 + 1) begin tests_failed++; $display("FAIL ferr_recover_count: got %0d exp %0d", vld_rises, r0 + 1); end
        else begin
            tests_run++;
            if (rx_bytes[r0] !== 8'h5A) begin tests_failed++; $display("FAIL ferr_recover_data: got %h exp 5a", rx_bytes[r0]); end
        end
        tests_run++;
        if (fe_cnt !== f0 + 1) begin tests_failed++; $display("FAIL ferr_single: got %0d exp %0d", fe_cnt, f0 + 1); end
    endtask

    task automatic test_glitch();
        int r0 = vld_rises;
        int e0 = fe_cnt + ov_cnt + pe_cnt;
        logic [7:0] d0 = bus.uart_rx_data_o;
        @(negedge clk);
        rx_line = 1'b0;
        repeat (3) @(negedge clk);
        rx_line = 1'b1;
        repeat (3 * PER) @(negedge clk);
        tests_run++;
        if (vld_rises !== r0) begin tests_failed++; $display("FAIL glitch_vld: got %0d exp %0d", vld_rises, r0); end
        tests_run++;
        if (fe_cnt + ov_cnt + pe_cnt !== e0) begin tests_failed++; $display("FAIL glitch_errors: got %0d exp %0d", fe_cnt + ov_cnt + pe_cnt, e0); end
        tests_run++;
        if (bus.uart_rx_data_o !== d0) begin tests_failed++; $display("FAIL glitch_data: got %h exp %h", bus.uart_rx_data_o, d0); end
        send_frame(8'h96, 1'b1, -1);
        repeat (3) @(negedge clk);
        tests_run++;
        if (vld_rises !== r0 + 1) begin tests_failed++; $display("FAIL glitch_recover: got %0d exp %0d", vld_rises, r0 + 1); end
        else begin
            tests_run++;
            if (rx_bytes[r0] !== 8'h96) begin tests_failed++; $display("FAIL glitch_recover_data: got %h exp 96", rx_bytes[r0]); end
        end
    endtask

    task automatic test_parity();
        int r0 = vld_rises;
        int p0 = pe_cnt;
`ifdef UART_RX_PARITY_EN
        par_flip = 1'b1;
        send_frame(8'h01, 1'b1, -1);
        par_flip = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (pe_cnt !== p0 + 1) begin tests_failed++; $display("FAIL parity_pulse: got %0d exp %0d", pe_cnt, p0 + 1); end
        tests_run++;
        if (vld_rises !== r0) begin tests_failed++; $display("FAIL parity_no_vld: got %0d exp %0d", vld_rises, r0); end
`else
        tests_run++;
        if (pe_cnt !== 0) begin tests_failed++; $display("FAIL parity_tied: got %0d exp 0", pe_cnt); end
        tests_run++;
        if (vld_rises !== r0) begin tests_failed++; $display("FAIL parity_idle_vld: got %0d exp %0d", vld_rises, r0); end
`endif
    endtask

    task automatic test_reset_mid_frame();
        int r0 = vld_rises;
        int e0 = fe_cnt + ov_cnt + pe_cnt;
        bus.uart_rx_data_rdy_i = 1'b1;
        send_frame(8'hC3, 1'b1, 4);
        repeat (2 * PER) @(negedge clk);
        tests_run++;
        if (vld_rises !== r0) begin tests_failed++; $display("FAIL rstmid_no_vld: got %0d exp %0d", vld_rises, r0); end
        tests_run++;
        if (fe_cnt + ov_cnt + pe_cnt !== e0) begin tests_failed++; $display("FAIL rstmid_errors: got %0d exp %0d", fe_cnt + ov_cnt + pe_cnt, e0); end
        send_frame(8'h3C, 1'b1, -1);
        repeat (3) @(negedge clk);
        tests_run++;
        if (vld_rises !== r0 + 1) begin tests_failed++; $display("FAIL rstmid_recover: got %0d exp %0d", vld_rises, r0 + 1); end
        else begin
            tests_run++;
            if (rx_bytes[r0] !== 8'h3C) begin tests_failed++; $display("FAIL rstmid_recover_data: got %h exp 3c", rx_bytes[r0]); end
        end
    endtask

    initial begin
        bus.uart_rx_data_rdy_i = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_overrun();
        test_frame_err();
        test_glitch();
        test_parity();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
